// File: rtl/bitboard_scanner_pkg.sv
// Shared constants, state encoding and small bit helpers for the bitboard scanner.
package bitboard_scanner_pkg;

  localparam int WIDTH = 32;
  localparam int IDX_W = 5;

  localparam logic [WIDTH-1:0] MASK_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [IDX_W:0]   CNT_ONE  = {{IDX_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    FIN  = 2'd2
  } state_t;

  // True when exactly one bit of the bitboard is set.
  function automatic logic is_single(input logic [WIDTH-1:0] v);
    return (v != '0) && ((v & (v - MASK_ONE)) == '0);
  endfunction

endpackage

// File: rtl/bitboard_scanner_if.sv
// Bitboard in / square-index out handshake bundle for the bitboard scanner.
interface bitboard_scanner_if;
  import bitboard_scanner_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_mask;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_square;
  logic             out_last;

  // Producer of bitboards and consumer of squares (testbench / upstream logic).
  modport master (
    output in_valid, in_mask, out_ready,
    input  in_ready, out_valid, out_square, out_last
  );

  // The scanner itself.
  modport slave (
    input  in_valid, in_mask, out_ready,
    output in_ready, out_valid, out_square, out_last
  );

endinterface

// File: rtl/bitboard_scanner_bit_index_encoder.sv
// Find-first-set over a bitboard. msb_first=0 picks the lowest set bit,
// msb_first=1 picks the highest. idx is 0 when no bit is set.
module bitboard_scanner_bit_index_encoder
  import bitboard_scanner_pkg::*;
#(
  parameter int W  = WIDTH,
  parameter int IW = IDX_W
) (
  input  logic [W-1:0]  vec,
  input  logic          msb_first,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Priority scan; the last match written wins, so loop direction sets priority.
  always_comb begin
    idx   = '0;
    found = |vec;
    if (msb_first) begin
      for (int i = 0; i < W; i++) begin
        if (vec[i]) idx = i[IW-1:0];
      end
    end else begin
      for (int i = W - 1; i >= 0; i--) begin
        if (vec[i]) idx = i[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/bitboard_scanner.sv
// Bitboard scanner: serializes a one-bit-per-square bitboard into square
// indices, one per out handshake, then pulses done.
// Build option: define BITBOARD_MSB_FIRST_EN to emit the highest set square
// first; by default squares come out lowest first.
module bitboard_scanner
  import bitboard_scanner_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  bitboard_scanner_if.slave   bus,
  output logic                done,
  output logic [IDX_W:0]      count,
  output logic                busy
);

`ifdef BITBOARD_MSB_FIRST_EN
  localparam logic MSB_FIRST = 1'b1;
`else
  localparam logic MSB_FIRST = 1'b0;
`endif

  state_t           state;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] next_rem;
  logic [IDX_W-1:0] next_idx;
  logic             next_found;
  logic             next_single;
  logic             out_hs;

  assign out_hs      = bus.out_valid & bus.out_ready;
  assign next_single = is_single(next_rem);

  // Remaining mask after this cycle: a fresh bitboard on accept, or the
  // current square removed on a transfer. Square index and last flag are
  // derived from it so they can be registered one cycle ahead.
  always_comb begin
    next_rem = rem;
    if (state == IDLE) begin
      next_rem = bus.in_mask;
    end else if (state == EMIT && out_hs) begin
      next_rem = rem & ~(MASK_ONE << bus.out_square);
    end
  end

  bitboard_scanner_bit_index_encoder #(
    .W  (WIDTH),
    .IW (IDX_W)
  ) u_enc (
    .vec       (next_rem),
    .msb_first (MSB_FIRST),
    .idx       (next_idx),
    .found     (next_found)
  );

  // Scan sequencer with registered handshake and status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      rem            <= '0;
      bus.in_ready   <= 1'b1;
      bus.out_valid  <= 1'b0;
      bus.out_square <= '0;
      bus.out_last   <= 1'b0;
      done           <= 1'b0;
      count          <= '0;
      busy           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.in_valid && bus.in_ready) begin
            rem          <= next_rem;
            count        <= '0;
            bus.in_ready <= 1'b0;
            busy         <= 1'b1;
            if (next_found) begin
              state          <= EMIT;
              bus.out_valid  <= 1'b1;
              bus.out_square <= next_idx;
              bus.out_last   <= next_single;
            end else begin
              // Empty bitboard: nothing to emit, go straight to completion.
              state <= FIN;
              done  <= 1'b1;
            end
          end
        end

        EMIT: begin
          if (flush) begin
            // Abort wins over a same-cycle transfer; count keeps what was sent.
            state          <= IDLE;
            rem            <= '0;
            bus.in_ready   <= 1'b1;
            bus.out_valid  <= 1'b0;
            bus.out_square <= '0;
            bus.out_last   <= 1'b0;
            busy           <= 1'b0;
          end else if (out_hs) begin
            rem   <= next_rem;
            count <= count + CNT_ONE;
            if (bus.out_last) begin
              state          <= FIN;
              bus.out_valid  <= 1'b0;
              bus.out_square <= '0;
              bus.out_last   <= 1'b0;
              done           <= 1'b1;
            end else begin
              bus.out_square <= next_idx;
              bus.out_last   <= next_single;
            end
          end
        end

        FIN: begin
          state        <= IDLE;
          done         <= 1'b0;
          bus.in_ready <= 1'b1;
          busy         <= 1'b0;
        end

        default: begin
          state          <= IDLE;
          rem            <= '0;
          bus.in_ready   <= 1'b1;
          bus.out_valid  <= 1'b0;
          bus.out_square <= '0;
          bus.out_last   <= 1'b0;
          done           <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitboard_scanner.sv
// Testbench for bitboard_scanner: table of bitboards scanned with out_ready
// held high, plus hand-written stall, flush and mid-scan reset sequences.
module tb_bitboard_scanner;
  import bitboard_scanner_pkg::*;

  logic           clock;
  logic           reset;
  logic           flush;
  logic           done;
  logic [IDX_W:0] count;
  logic           busy;

  int n_total;
  int n_pass;

  bitboard_scanner_if bif ();

  bitboard_scanner dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bif.slave),
    .done  (done),
    .count (count),
    .busy  (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] mask;
    int          exp_count;
    int          exp_first;   // lowest-first order; -1 when nothing is emitted
    int          exp_final;
  } vec_t;

  vec_t vecs [6];

`ifdef BITBOARD_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference pick of the next square from a remaining mask.
  function automatic int pick(input logic [31:0] m);
    int r;
    r = -1;
    for (int i = 0; i < 32; i++) begin
      if (m[i] && (MSB || r < 0)) r = i;
    end
    return r;
  endfunction

  function automatic int popc(input logic [31:0] m);
    int c;
    c = 0;
    for (int i = 0; i < 32; i++) c += int'(m[i]);
    return c;
  endfunction

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    while (bif.in_ready !== 1'b1 && k < 50) begin
      @(negedge clock);
      k++;
    end
    if (k >= 50) check({name, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  // Accept a bitboard at the next posedge; returns at the negedge of cycle N+1.
  task automatic load(input logic [31:0] m);
    bif.in_valid = 1'b1;
    bif.in_mask  = m;
    @(negedge clock);
    bif.in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    logic [31:0] rem;
    int          emitted, cyc, first_sq, final_sq, e_first, e_final;
    bit          got_done, ok_seq;
    string       tag;
    tag      = $sformatf("vec%0d", n);
    rem      = v.mask;
    emitted  = 0;
    first_sq = -1;
    final_sq = -1;
    ok_seq   = 1'b1;
    got_done = 1'b0;
    e_first  = MSB ? v.exp_final : v.exp_first;
    e_final  = MSB ? v.exp_first : v.exp_final;
    wait_ready(tag);
    bif.out_ready = 1'b1;
    load(v.mask);
    for (cyc = 0; cyc < 40 && !got_done; cyc++) begin
      if (bif.out_valid === 1'b1) begin
        if (int'(bif.out_square) != pick(rem)) ok_seq = 1'b0;
        if (bif.out_last !== (popc(rem) == 1)) ok_seq = 1'b0;
        if (done !== 1'b0 || bif.in_ready !== 1'b0 || busy !== 1'b1) ok_seq = 1'b0;
        if (int'(count) != emitted) ok_seq = 1'b0;
        if (first_sq < 0) first_sq = int'(bif.out_square);
        final_sq = int'(bif.out_square);
        rem[bif.out_square] = 1'b0;
        emitted++;
      end else if (done === 1'b1) begin
        got_done = 1'b1;
        check({tag, "_done_cycle"}, cyc, v.exp_count);
        check({tag, "_count"}, 32'(count), v.exp_count);
        check({tag, "_ready_in_fin"}, 32'(bif.in_ready), 32'd0);
      end else begin
        ok_seq = 1'b0;
      end
      if (!got_done) @(negedge clock);
    end
    if (!got_done) check({tag, "_done_timeout"}, 32'd0, 32'd1);
    check({tag, "_sequence"}, 32'(ok_seq), 32'd1);
    check({tag, "_first"}, first_sq, e_first);
    check({tag, "_final"}, final_sq, e_final);
    @(negedge clock);
    check({tag, "_idle_ready"}, {29'd0, bif.in_ready, done, busy}, 32'd4);
    check({tag, "_count_hold"}, 32'(count), v.exp_count);
  endtask

  initial begin
    int s_first, s_second;
    n_total = 0;
    n_pass  = 0;

    vecs[0] = '{32'h0000_0000,  0, -1, -1};
    vecs[1] = '{32'h8000_0011,  3,  0, 31};
    vecs[2] = '{32'h0000_0001,  1,  0,  0};
    vecs[3] = '{32'h8000_0000,  1, 31, 31};
    vecs[4] = '{32'hFFFF_FFFF, 32,  0, 31};
    vecs[5] = '{32'h00A0_0400,  3, 10, 23};

    reset         = 1'b1;
    flush         = 1'b0;
    bif.in_valid  = 1'b0;
    bif.in_mask   = '0;
    bif.out_ready = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset_in_ready",  32'(bif.in_ready),  32'd1);
    check("reset_out_valid", 32'(bif.out_valid), 32'd0);
    check("reset_out_sq",    32'(bif.out_square), 32'd0);
    check("reset_out_last",  32'(bif.out_last),  32'd0);
    check("reset_done_busy", {30'd0, done, busy}, 32'd0);
    check("reset_count",     32'(count),         32'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Stall: first square held while out_ready is low for three cycles.
    s_first  = MSB ? 6 : 4;
    s_second = MSB ? 4 : 6;
    wait_ready("stall");
    bif.out_ready = 1'b0;
    load(32'h0000_0050);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall_hold_sq%0d", k), 32'(bif.out_square), s_first);
      check($sformatf("stall_hold_vl%0d", k), {30'd0, bif.out_valid, bif.out_last}, 32'd2);
      check($sformatf("stall_hold_cnt%0d", k), 32'(count), 32'd0);
      @(negedge clock);
    end
    bif.out_ready = 1'b1;
    @(negedge clock);
    check("stall_second_sq", 32'(bif.out_square), s_second);
    check("stall_second_vl", {30'd0, bif.out_valid, bif.out_last}, 32'd3);
    check("stall_second_cnt", 32'(count), 32'd1);
    @(negedge clock);
    check("stall_done", 32'(done), 32'd1);
    check("stall_count", 32'(count), 32'd2);
    @(negedge clock);

    // Flush after the first square transfers; flush beats the same-cycle out_ready.
    wait_ready("flush");
    bif.out_ready = 1'b1;
    load(32'h0000_F000);
    check("flush_first_sq", 32'(bif.out_square), MSB ? 32'd15 : 32'd12);
    @(negedge clock);
    check("flush_cnt_before", 32'(count), 32'd1);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check("flush_out_valid", 32'(bif.out_valid), 32'd0);
    check("flush_no_done",   32'(done), 32'd0);
    check("flush_count",     32'(count), 32'd1);
    check("flush_ready_busy", {30'd0, bif.in_ready, busy}, 32'd2);
    @(negedge clock);
    check("flush_still_no_done", {30'd0, done, bif.out_valid}, 32'd0);

    // Reset in the middle of a scan returns everything to reset values.
    bif.out_ready = 1'b1;
    load(32'h0000_F000);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_mid_in_ready",  32'(bif.in_ready),  32'd1);
    check("rst_mid_out",       {29'd0, bif.out_valid, bif.out_last, done}, 32'd0);
    check("rst_mid_out_sq",    32'(bif.out_square), 32'd0);
    check("rst_mid_count",     32'(count), 32'd0);
    check("rst_mid_busy",      32'(busy), 32'd0);

    // A scan after the mid-scan reset still behaves normally.
    run_vec(vecs[1], 6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
